xcorr_sync_ctrl: RTL and testbench

Controller that sequences the combinational `xcorr_proc` correlator to find a sync pattern in a serial bit stream. It shifts received bits into an NDATA-bit sliding window and presents the window and a latched reference pattern to an external `xcorr_proc` instance. It evaluates the returned match score after every window update. It reports the first offset whose score reaches a programmable threshold, or a timeout, and tracks the peak score seen during the search.

---
 rtl/xcorr_sync_ctrl.sv | 132 +++++++++++++
 tb/tb_xcorr_sync_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xcorr_sync_ctrl.sv
// Sync-pattern search controller: slides received bits through an NDATA-bit window,
// drives an external xcorr_proc, and reports the first threshold hit or a timeout.
module xcorr_sync_ctrl #(
    parameter int NDATA     = 128,
    parameter int TIMEOUT   = 1024,
    parameter int NDATA_LOG = $clog2(NDATA),
    parameter int CNT_W     = $clog2(TIMEOUT + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NDATA-1:0]     pattern,
    input  logic [NDATA_LOG:0]   threshold,
    input  logic                 bit_valid,
    input  logic                 bit_in,
    output logic [NDATA-1:0]     xc_dinA,
    output logic [NDATA-1:0]     xc_dinB,
    input  logic [NDATA_LOG:0]   xc_score,
    output logic                 busy,
    output logic                 found,
    output logic                 timeout,
    output logic [NDATA_LOG:0]   peak_score,
    output logic [CNT_W-1:0]     peak_offset,
    output logic [CNT_W-1:0]     hit_offset
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        SEARCH
    } state_t;

    localparam logic [CNT_W-1:0] NDATA_C   = CNT_W'(NDATA);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t               state;
    logic [NDATA-1:0]     win;
    logic [NDATA-1:0]     pat_q;
    logic [NDATA_LOG:0]   thr_q;
    logic [CNT_W-1:0]     cnt;
    logic                 eval;

    logic                 accept;
    logic [CNT_W-1:0]     cnt_nxt;
    logic                 hit;
    logic                 last;
    logic                 first_eval;

    // Bits beyond TIMEOUT are refused so the counter can never wrap.
    assign accept     = bit_valid && (state != IDLE) && (cnt != TIMEOUT_C);
    assign cnt_nxt    = cnt + CNT_W'(1);
    assign hit        = (xc_score >= thr_q);
    assign last       = (cnt == TIMEOUT_C);
    assign first_eval = (cnt == NDATA_C);

    assign xc_dinA = pat_q;
    assign xc_dinB = win;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            win         <= '0;
            pat_q       <= '0;
            thr_q       <= '0;
            cnt         <= '0;
            eval        <= 1'b0;
            busy        <= 1'b0;
            found       <= 1'b0;
            timeout     <= 1'b0;
            peak_score  <= '0;
            peak_offset <= '0;
            hit_offset  <= '0;
        end else begin
            found   <= 1'b0;
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        pat_q       <= pattern;
                        thr_q       <= threshold;
                        win         <= '0;
                        cnt         <= '0;
                        eval        <= 1'b0;
                        peak_score  <= '0;
                        peak_offset <= '0;
                        hit_offset  <= '0;
                        busy        <= 1'b1;
                        state       <= FILL;
                    end
                end
                default: begin
                    if (abort) begin
                        eval  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        eval <= 1'b0;
                        if (accept) begin
                            win  <= {win[NDATA-2:0], bit_in};
                            cnt  <= cnt_nxt;
                            eval <= (cnt_nxt >= NDATA_C);
                            if (state == FILL && cnt_nxt == NDATA_C) begin
                                state <= SEARCH;
                            end
                        end
                        if (eval) begin
                            // The first evaluated window always seeds the peak, even at score 0.
                            if (first_eval || xc_score > peak_score) begin
                                peak_score  <= xc_score;
                                peak_offset <= cnt;
                            end
                            if (hit) begin
                                found      <= 1'b1;
                                hit_offset <= cnt;
                                eval       <= 1'b0;
                                busy       <= 1'b0;
                                state      <= IDLE;
                            end else if (last) begin
                                timeout <= 1'b1;
                                eval    <= 1'b0;
                                busy    <= 1'b0;
                                state   <= IDLE;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xcorr_sync_ctrl.sv
// Randomized bench for xcorr_sync_ctrl; expected results come from a window-scan model.
module tb_xcorr_sync_ctrl;

    localparam int NDATA   = 128;
    localparam int TIMEOUT = 256;
    localparam int SW      = 8;
    localparam int CW      = 9;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [NDATA-1:0]  pattern;
    logic [SW-1:0]     threshold;
    logic              bit_valid;
    logic              bit_in;
    logic [NDATA-1:0]  xc_dinA;
    logic [NDATA-1:0]  xc_dinB;
    logic [SW-1:0]     xc_score;
    logic              busy;
    logic              found;
    logic              timeout;
    logic [SW-1:0]     peak_score;
    logic [CW-1:0]     peak_offset;
    logic [CW-1:0]     hit_offset;

    int nvec = 0;
    int nerr = 0;

    logic tb_bits [0:TIMEOUT-1];
    bit   m_found;
    int   m_n;
    int   m_pk;
    int   m_pko;

    always #5 clk = ~clk;

    // Stand-in for the external correlator: count of agreeing bit positions.
    assign xc_score = SW'(NDATA - $countones(xc_dinA ^ xc_dinB));

    xcorr_sync_ctrl #(
        .NDATA   (NDATA),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .pattern     (pattern),
        .threshold   (threshold),
        .bit_valid   (bit_valid),
        .bit_in      (bit_in),
        .xc_dinA     (xc_dinA),
        .xc_dinB     (xc_dinB),
        .xc_score    (xc_score),
        .busy        (busy),
        .found       (found),
        .timeout     (timeout),
        .peak_score  (peak_score),
        .peak_offset (peak_offset),
        .hit_offset  (hit_offset)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Scan every full window of the first nbits bits and apply the hit/timeout rules.
    task automatic model(input logic [NDATA-1:0] pat, input int thr, input int nbits);
        logic [NDATA-1:0] w;
        int sc;
        m_found = 0;
        m_n     = -1;
        m_pk    = 0;
        m_pko   = 0;
        for (int n = NDATA; n <= nbits; n++) begin
            for (int j = 0; j < NDATA; j++) w[NDATA-1-j] = tb_bits[n-NDATA+j];
            sc = NDATA - $countones(w ^ pat);
            if (n == NDATA || sc > m_pk) begin
                m_pk  = sc;
                m_pko = n;
            end
            if (sc >= thr) begin
                m_found = 1;
                m_n     = n;
                break;
            end
            if (n == TIMEOUT) begin
                m_n = n;
                break;
            end
        end
    endtask

    task automatic load_pattern(input logic [NDATA-1:0] pat, input int offs);
        for (int j = 0; j < NDATA; j++) tb_bits[offs+j] = pat[NDATA-1-j];
    endtask

    task automatic fill_random();
        for (int j = 0; j < TIMEOUT; j++) tb_bits[j] = 1'($urandom_range(0, 1));
    endtask

    task automatic do_start(input logic [NDATA-1:0] pat, input logic [SW-1:0] thr);
        start     = 1'b1;
        pattern   = pat;
        threshold = thr;
        @(negedge clk);
        start   = 1'b0;
        pattern = ~pat;
        chk("busy_after_start", busy, 1);
        chk("dinA_latched", xc_dinA, pat);
        chk("peak_cleared", peak_score, 0);
    endtask

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) begin
            bit_valid = 1'b1;
            bit_in    = tb_bits[i];
            @(negedge clk);
        end
        bit_valid = 1'b0;
    endtask

    task automatic run_search(input logic [NDATA-1:0] pat, input logic [SW-1:0] thr,
                              input int nbits, input bit gaps, input bit poke);
        int  idx, cyc, drv_cyc, pulse_cyc;
        bit  got_f, got_t, pulse_busy, poked;
        model(pat, int'(thr), nbits);
        do_start(pat, thr);
        idx = 0; cyc = 0; drv_cyc = -100; pulse_cyc = -50;
        got_f = 0; got_t = 0; pulse_busy = 1; poked = 0;
        while (!got_f && !got_t && cyc < 2000) begin
            start = 1'b0;
            if (poke && idx == 10 && !poked) begin
                start     = 1'b1;
                pattern   = ~pat;
                threshold = '0;
                poked     = 1;
            end
            if (idx < nbits && (!gaps || $urandom_range(0, 3) != 0)) begin
                bit_valid = 1'b1;
                bit_in    = tb_bits[idx];
                if (idx == m_n - 1) drv_cyc = cyc;
                idx++;
            end else begin
                bit_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (found)   got_f = 1;
            if (timeout) got_t = 1;
            if (found || timeout) begin
                pulse_cyc  = cyc;
                pulse_busy = busy;
            end
        end
        start     = 1'b0;
        bit_valid = 1'b0;
        chk("found", got_f, m_found);
        chk("timeout", got_t, !m_found);
        chk("latency", pulse_cyc - drv_cyc, 2);
        chk("busy_at_pulse", pulse_busy, 0);
        chk("peak_score", peak_score, m_pk);
        chk("peak_offset", peak_offset, m_pko);
        chk("hit_offset", hit_offset, m_found ? m_n : 0);
        chk("dinA_held", xc_dinA, pat);
        @(negedge clk);
        chk("pulse_width", found | timeout, 0);
    endtask

    initial begin
        logic [NDATA-1:0] pat_f0, pat;

        rst = 1'b1; start = 1'b0; abort = 1'b0; pattern = '0; threshold = '0;
        bit_valid = 1'b0; bit_in = 1'b0;
        pat_f0 = {16{8'hF0}};
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_found", found, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_peak", peak_score, 0);
        chk("rst_peak_off", peak_offset, 0);
        chk("rst_hit_off", hit_offset, 0);
        chk("rst_dinA", xc_dinA, 0);
        chk("rst_dinB", xc_dinB, 0);
        rst = 1'b0;
        @(negedge clk);

        // Exact match, no gaps
        load_pattern(pat_f0, 0);
        run_search(pat_f0, 8'd128, NDATA, 0, 0);
        chk("exact_hit_offset", hit_offset, 128);

        // 40 alternating bits then the pattern, with bit_valid gaps
        for (int j = 0; j < 40; j++) tb_bits[j] = (j % 2 == 0);
        load_pattern(pat_f0, 40);
        run_search(pat_f0, 8'd128, 168, 1, 0);
        chk("offset_hit_offset", hit_offset, 168);

        // All-zero stream against all-ones pattern times out
        for (int j = 0; j < TIMEOUT; j++) tb_bits[j] = 1'b0;
        run_search({NDATA{1'b1}}, 8'd1, TIMEOUT, 1, 0);
        chk("tmo_peak_offset", peak_offset, 128);

        // Threshold 0 hits on the first evaluated window
        fill_random();
        run_search({$urandom(), $urandom(), $urandom(), $urandom()}, 8'd0, TIMEOUT, 1, 0);
        chk("thr0_hit_offset", hit_offset, 128);

        // Unreachable threshold with exact-match data
        fill_random();
        load_pattern(pat_f0, 0);
        run_search(pat_f0, 8'd129, TIMEOUT, 1, 0);
        chk("thr129_peak", peak_score, 128);

        // Hit on the very last permitted bit
        fill_random();
        pat = {$urandom(), $urandom(), $urandom(), $urandom()};
        load_pattern(pat, TIMEOUT - NDATA);
        run_search(pat, 8'd128, TIMEOUT, 1, 0);
        chk("last_bit_hit", hit_offset, 256);

        // Abort during FILL
        fill_random();
        do_start(pat, 8'd128);
        feed(60);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_fill_busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            bit_valid = 1'b1;
            bit_in    = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("abort_fill_no_pulse", found | timeout, 0);
        end
        bit_valid = 1'b0;
        chk("abort_fill_peak", peak_score, 0);

        // Abort in SEARCH with an evaluation pending: that window is dropped
        fill_random();
        model(pat, 129, 149);
        do_start(pat, 8'd129);
        feed(150);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_search_busy", busy, 0);
        chk("abort_search_no_pulse", found | timeout, 0);
        chk("abort_search_peak", peak_score, m_pk);
        chk("abort_search_peak_off", peak_offset, m_pko);

        // Restart exact match, with a start poke mid-search that must be ignored
        load_pattern(pat_f0, 0);
        run_search(pat_f0, 8'd128, NDATA, 0, 1);

        // Asynchronous reset in the middle of SEARCH
        fill_random();
        do_start(pat, 8'd129);
        feed(200);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_peak", peak_score, 0);
        chk("midrst_peak_off", peak_offset, 0);
        chk("midrst_dinA", xc_dinA, 0);
        chk("midrst_dinB", xc_dinB, 0);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_no_pulse", found | timeout, 0);

        // Random patterns, thresholds and data
        for (int r = 0; r < 6; r++) begin
            fill_random();
            pat = {$urandom(), $urandom(), $urandom(), $urandom()};
            run_search(pat, SW'($urandom_range(70, 84)), TIMEOUT, 1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
